// File: rtl/mmc1_pkg.sv
// Shared MMC1 definitions: register indices, bus constants and the register address window helper.
package mmc1_pkg;

  localparam int unsigned MMC1_ADDR_W = 16;
  localparam int unsigned MMC1_DATA_W = 8;
  localparam int unsigned MMC1_VAL_W  = 5;
  localparam int unsigned MMC1_K_W    = 3;

  localparam logic [MMC1_DATA_W-1:0] MMC1_RESET_DATA = 8'h80;
  localparam logic [MMC1_DATA_W-1:0] MMC1_IDLE_DATA  = 8'hFF;
  localparam logic [MMC1_ADDR_W-1:0] MMC1_IDLE_ADDR  = 16'h0000;
  localparam logic [MMC1_ADDR_W-1:0] MMC1_RESET_ADDR = 16'h8000;
  localparam logic [MMC1_K_W-1:0]    MMC1_K_LAST     = 3'd4;

  typedef enum logic [1:0] {
    MMC1_CONTROL = 2'd0,
    MMC1_CHR0    = 2'd1,
    MMC1_CHR1    = 2'd2,
    MMC1_PRG     = 2'd3
  } mmc1_reg_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST_WR,
    ST_BIT_WR,
    ST_GAP
  } mmc1_state_e;

  typedef struct packed {
    mmc1_reg_e             idx;
    logic [MMC1_VAL_W-1:0] val;
    logic                  shift_reset;
  } mmc1_req_t;

  function automatic logic [MMC1_ADDR_W-1:0] mmc1_reg_addr(input mmc1_reg_e idx);
    return {1'b1, idx, 13'h0};
  endfunction

endpackage

// File: rtl/m2_phase_gen.sv
// Free-running M2 generator. fall/update are high during the clk cycle whose closing edge
// is the m2 falling edge (ph -> 0) or the output-update edge (ph -> 1) respectively.
module m2_phase_gen #(
  parameter int unsigned M2_DIV = 6
) (
  input  logic clk,
  input  logic reset,
  output logic m2,
  output logic fall,
  output logic update
);

  localparam int unsigned PH_N = 2 * M2_DIV;
  localparam int unsigned PH_W = $clog2(PH_N);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PH_N - 1);
  localparam logic [PH_W-1:0] PH_HIGH = PH_W'(M2_DIV);

  logic [PH_W-1:0] ph;
  logic [PH_W-1:0] ph_nxt;

  always_comb ph_nxt = (ph == PH_LAST) ? '0 : ph + PH_W'(1);

  // update resets high because ph resets to 0, so the first edge is an update edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph     <= '0;
      m2     <= 1'b0;
      fall   <= 1'b0;
      update <= 1'b1;
    end else begin
      ph     <= ph_nxt;
      m2     <= (ph_nxt >= PH_HIGH);
      fall   <= (ph_nxt == PH_LAST);
      update <= (ph_nxt == '0);
    end
  end

endmodule

// File: rtl/mmc1_serial_writer.sv
// Turns a parallel MMC1 register write into the 5-write serial sequence (optionally preceded
// by a shift-reset write) on a generated CPU bus, one idle cycle between writes.
module mmc1_serial_writer
  import mmc1_pkg::*;
#(
  parameter int unsigned M2_DIV = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_reg,
  input  logic [MMC1_VAL_W-1:0]  req_data,
  input  logic                   req_reset,
  output logic                   m2,
  output logic [MMC1_ADDR_W-1:0] cpu_addr,
  output logic [MMC1_DATA_W-1:0] cpu_data,
  output logic                   cpu_rw,
  output logic                   busy,
  output logic                   done
);

  logic fall;
  logic update;

  m2_phase_gen #(.M2_DIV(M2_DIV)) u_phase (
    .clk    (clk),
    .reset  (reset),
    .m2     (m2),
    .fall   (fall),
    .update (update)
  );

  mmc1_state_e           state, state_nxt;
  logic [MMC1_K_W-1:0]   k, k_nxt;
  logic                  armed, armed_nxt;
  logic                  after_rst, after_rst_nxt;
  mmc1_req_t             req_q;
  logic                  accept_c;
  logic                  rw_nxt, done_nxt, ready_nxt;
  logic [MMC1_ADDR_W-1:0] addr_nxt;
  logic [MMC1_DATA_W-1:0] data_nxt;

  assign accept_c = req_valid && req_ready;

  // armed marks an accepted request still waiting in IDLE for the next update edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      k         <= '0;
      armed     <= 1'b0;
      after_rst <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      armed     <= armed_nxt;
      after_rst <= after_rst_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q <= '0;
    end else if (accept_c) begin
      req_q <= '{idx: mmc1_reg_e'(req_reg), val: req_data, shift_reset: req_reset};
    end
  end

  always_comb begin
    state_nxt     = state;
    k_nxt         = k;
    armed_nxt     = armed;
    after_rst_nxt = after_rst;
    if (accept_c) begin
      armed_nxt = 1'b1;
      k_nxt     = '0;
    end
    if (update) begin
      case (state)
        ST_IDLE: begin
          if (armed) begin
            state_nxt = req_q.shift_reset ? ST_RST_WR : ST_BIT_WR;
            armed_nxt = 1'b0;
          end
        end
        ST_RST_WR: begin
          state_nxt     = ST_GAP;
          after_rst_nxt = 1'b1;
        end
        ST_BIT_WR: begin
          state_nxt     = ST_GAP;
          after_rst_nxt = 1'b0;
        end
        ST_GAP: begin
          if (after_rst) begin
            state_nxt = ST_BIT_WR;
            k_nxt     = '0;
          end else if (k == MMC1_K_LAST) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_BIT_WR;
            k_nxt     = k + MMC1_K_W'(1);
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // bus outputs only move on update edges; they follow the state being entered
  always_comb begin
    rw_nxt   = cpu_rw;
    addr_nxt = cpu_addr;
    data_nxt = cpu_data;
    if (update) begin
      case (state_nxt)
        ST_RST_WR: begin
          rw_nxt   = 1'b0;
          addr_nxt = MMC1_RESET_ADDR;
          data_nxt = MMC1_RESET_DATA;
        end
        ST_BIT_WR: begin
          rw_nxt   = 1'b0;
          addr_nxt = mmc1_reg_addr(req_q.idx);
          data_nxt = {{(MMC1_DATA_W-1){1'b0}}, req_q.val[k_nxt]};
        end
        default: begin
          rw_nxt   = 1'b1;
          addr_nxt = MMC1_IDLE_ADDR;
          data_nxt = MMC1_IDLE_DATA;
        end
      endcase
    end
    done_nxt  = update && (state == ST_GAP) && !after_rst && (k == MMC1_K_LAST);
    ready_nxt = (state_nxt == ST_IDLE) && !armed_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_rw    <= 1'b1;
      cpu_addr  <= MMC1_IDLE_ADDR;
      cpu_data  <= MMC1_IDLE_DATA;
      done      <= 1'b0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      cpu_rw    <= rw_nxt;
      cpu_addr  <= addr_nxt;
      cpu_data  <= data_nxt;
      done      <= done_nxt;
      req_ready <= ready_nxt;
      busy      <= !ready_nxt;
    end
  end

  // the MMC1 samples on the m2 falling edge, so the bus must not move there
  a_stable_on_fall: assert property (@(posedge clk) disable iff (reset)
    fall |=> $stable({cpu_addr, cpu_data, cpu_rw}));

endmodule

// File: tb/tb_mmc1_serial_writer.sv
// Bench for mmc1_serial_writer: two instances (M2_DIV 6 and 2) checked against a bus-cycle
// transcript and a behavioural MMC1 shift-register model.
module tb_mmc1_serial_writer;

  localparam int DIV0 = 6;
  localparam int DIV1 = 2;
  localparam logic [24:0] IDLE_CYC = {1'b1, 16'h0000, 8'hFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0][1:0]  req_reg;
  logic [1:0][4:0]  req_data;
  logic [1:0]       req_reset;
  logic [1:0]       m2;
  logic [1:0][15:0] cpu_addr;
  logic [1:0][7:0]  cpu_data;
  logic [1:0]       cpu_rw;
  logic [1:0]       busy;
  logic [1:0]       done;

  mmc1_serial_writer #(.M2_DIV(DIV0)) dut0 (
    .clk(clk), .reset(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_reg(req_reg[0]), .req_data(req_data[0]), .req_reset(req_reset[0]), .m2(m2[0]),
    .cpu_addr(cpu_addr[0]), .cpu_data(cpu_data[0]), .cpu_rw(cpu_rw[0]), .busy(busy[0]),
    .done(done[0])
  );

  mmc1_serial_writer #(.M2_DIV(DIV1)) dut1 (
    .clk(clk), .reset(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_reg(req_reg[1]), .req_data(req_data[1]), .req_reset(req_reset[1]), .m2(m2[1]),
    .cpu_addr(cpu_addr[1]), .cpu_data(cpu_data[1]), .cpu_rw(cpu_rw[1]), .busy(busy[1]),
    .done(done[1])
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Bus monitor + MMC1 model: one bus cycle is whatever the bus held when m2 fell.
  logic [24:0] cyc_q [2][$];
  logic [24:0] prev_bus [2];
  logic        prev_m2 [2];
  logic        last_wr [2];
  int          viol [2]   = '{0, 0};
  int          consec [2] = '{0, 0};
  logic [4:0]  mregs [2][4] = '{default: '0};
  logic [4:0]  msr [2]      = '{default: '0};
  int          mcnt [2]     = '{0, 0};

  function automatic logic [24:0] bus_now(input int g);
    return {cpu_rw[g], cpu_addr[g], cpu_data[g]};
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst[g]) begin
        prev_m2[g] <= 1'b0;
        last_wr[g] <= 1'b0;
      end else begin
        if (prev_m2[g] && !m2[g]) begin
          if (bus_now(g) != prev_bus[g]) viol[g] <= viol[g] + 1;
          cyc_q[g].push_back(prev_bus[g]);
          if (!prev_bus[g][24]) begin
            if (last_wr[g]) begin
              consec[g] <= consec[g] + 1;
            end else if (prev_bus[g][23]) begin
              if (prev_bus[g][7]) begin
                msr[g]      <= '0;
                mcnt[g]     <= 0;
                mregs[g][0] <= mregs[g][0] | 5'h0C;
              end else if (mcnt[g] == 4) begin
                mregs[g][prev_bus[g][22:21]] <= {prev_bus[g][0], msr[g][4:1]};
                msr[g]  <= '0;
                mcnt[g] <= 0;
              end else begin
                msr[g]  <= {prev_bus[g][0], msr[g][4:1]};
                mcnt[g] <= mcnt[g] + 1;
              end
            end
          end
          last_wr[g] <= !prev_bus[g][24];
        end
        prev_m2[g] <= m2[g];
      end
      prev_bus[g] <= bus_now(g);
    end
  end

  function automatic int div_of(input int s);
    return (s == 0) ? DIV0 : DIV1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input int s, input string tag);
    chk({tag, "_m2"},    32'(m2[s]),        32'd0);
    chk({tag, "_rw"},    32'(cpu_rw[s]),    32'd1);
    chk({tag, "_addr"},  32'(cpu_addr[s]),  32'h0000);
    chk({tag, "_data"},  32'(cpu_data[s]),  32'hFF);
    chk({tag, "_ready"}, 32'(req_ready[s]), 32'd1);
    chk({tag, "_busy"},  32'(busy[s]),      32'd0);
    chk({tag, "_done"},  32'(done[s]),      32'd0);
  endtask

  // Issue one request and compare the resulting bus transcript with the protocol's sequence.
  task automatic run_req(input int s, input logic [1:0] r, input logic [4:0] d,
                         input logic rf, input bit hold);
    logic [24:0] expq[$];
    logic [24:0] v;
    int div, start, lat, n, i;
    div = div_of(s);
    if (rf) begin
      expq.push_back({1'b0, 16'h8000, 8'h80});
      expq.push_back(IDLE_CYC);
    end
    for (int b = 0; b < 5; b++) begin
      expq.push_back({1'b0, 1'b1, r, 13'h0, 7'h0, d[b]});
      expq.push_back(IDLE_CYC);
    end
    req_reg[s] = r; req_data[s] = d; req_reset[s] = rf; req_valid[s] = 1'b1;
    n = 0;
    while (req_ready[s] !== 1'b1 && n < 64 * div) begin tick(); n++; end
    chk("ready_before_accept", 32'(req_ready[s]), 32'd1);
    tick();
    start = cyc_q[s].size();
    chk("busy_after_accept", 32'(busy[s]), 32'd1);
    if (!hold) begin
      req_valid[s] = 1'b0;
      req_reg[s] = 2'($urandom); req_data[s] = 5'($urandom); req_reset[s] = 1'($urandom);
    end
    lat = 0;
    while (cpu_rw[s] !== 1'b0 && lat < 4 * div) begin tick(); lat++; end
    chk("first_write_latency", 32'(lat >= 1 && lat <= 2 * div), 32'd1);
    n = 0;
    while (done[s] !== 1'b1 && n < 32 * div) begin tick(); n++; end
    chk("done_seen", 32'(done[s]), 32'd1);
    chk("ready_at_done", 32'(req_ready[s]), 32'd1);
    i = start;
    while (i < cyc_q[s].size() && cyc_q[s][i] == IDLE_CYC) i++;
    chk("bus_cycle_count", 32'(cyc_q[s].size() - i), 32'(expq.size()));
    for (int j = 0; j < expq.size(); j++) begin
      v = 'x;
      if (i + j < cyc_q[s].size()) v = cyc_q[s][i + j];
      chk($sformatf("cycle%0d", j), 32'(v), 32'(expq[j]));
    end
    if (!hold) begin
      tick();
      chk("done_single_pulse", 32'(done[s]), 32'd0);
    end
  endtask

  initial begin
    logic [1:0] r;
    logic [4:0] d;
    logic       rf;
    int         div, nt, iv, wr_seen;
    logic       last_m2, prev_rw;
    rst = 2'b00;
    req_valid = '0; req_reg = '0; req_data = '0; req_reset = '0;
    #1 rst = 2'b11;
    for (int s = 0; s < 2; s++) begin
      div = div_of(s);
      repeat (3) tick();
      chk_reset_vals(s, "in_reset");
      rst[s] = 1'b0;

      // idle: m2 toggles every M2_DIV clks, bus stays idle
      nt = 0; iv = 0; last_m2 = m2[s];
      for (int c = 0; c < 6 * div; c++) begin
        tick();
        iv++;
        if (m2[s] !== last_m2) begin
          if (nt > 0) chk("m2_half_period", 32'(iv), 32'(div));
          nt++; iv = 0; last_m2 = m2[s];
        end
      end
      chk("m2_toggled", 32'(nt >= 5), 32'd1);
      chk("idle_bus", 32'({cpu_rw[s], cpu_addr[s], cpu_data[s]}), 32'(IDLE_CYC));
      chk("idle_ready", 32'(req_ready[s]), 32'd1);

      run_req(s, 2'd3, 5'b10110, 1'b0, 1'b0);
      chk("prg_bank_16", 32'(mregs[s][3]), 32'h16);
      run_req(s, 2'd0, 5'h0F, 1'b1, 1'b0);
      chk("control_0f", 32'(mregs[s][0]), 32'h0F);

      // back-to-back with req_valid held high
      run_req(s, 2'd1, 5'h03, 1'b0, 1'b1);
      chk("b2b_done_high", 32'(done[s]), 32'd1);
      run_req(s, 2'd2, 5'h1C, 1'b0, 1'b0);
      chk("chr0_03", 32'(mregs[s][1]), 32'h03);
      chk("chr1_1c", 32'(mregs[s][2]), 32'h1C);

      for (int t = 0; t < 4; t++) begin
        r = 2'($urandom); d = 5'($urandom); rf = 1'($urandom);
        run_req(s, r, d, rf, 1'b0);
        chk($sformatf("rand_reg%0d", r), 32'(mregs[s][r]), 32'(d));
      end

      // reset in the middle of the third bit write
      req_reg[s] = 2'd2; req_data[s] = 5'($urandom); req_reset[s] = 1'b0; req_valid[s] = 1'b1;
      tick();
      req_valid[s] = 1'b0;
      wr_seen = 0; prev_rw = cpu_rw[s];
      for (int c = 0; c < 64 * div && wr_seen < 3; c++) begin
        tick();
        if (prev_rw === 1'b1 && cpu_rw[s] === 1'b0) wr_seen++;
        prev_rw = cpu_rw[s];
      end
      chk("third_write_reached", 32'(wr_seen), 32'd3);
      rst[s] = 1'b1;
      #1;
      chk_reset_vals(s, "mid_reset");
      repeat (3) tick();
      rst[s] = 1'b0;
      repeat (2) tick();
      run_req(s, 2'd3, 5'h07, 1'b1, 1'b0);
      chk("prg_after_reset_07", 32'(mregs[s][3]), 32'h07);

      repeat (2 * div) tick();
      chk("bus_moved_on_fall", 32'(viol[s]), 32'd0);
      chk("consecutive_writes", 32'(consec[s]), 32'd0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
